// File: rtl/axi_pkg.sv
// axi_pkg: AXI response/burst constants and crossbar FSM state types
package axi_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  typedef enum logic [1:0] {RD_IDLE, RD_FWD, RD_ERR} rd_state_t;
  typedef enum logic [2:0] {WR_IDLE, WR_DATA, WR_RESP, WR_ERRD, WR_ERRB} wr_state_t;
endpackage

// File: rtl/axi_addr_decode.sv
// axi_addr_decode: address to slave index (lowest region wins), err when routed to the local DECERR sink
module axi_addr_decode #(
  parameter int NSLV = 2,
  parameter int AW = 32,
  parameter logic [NSLV*AW-1:0] REGION_BASE = {32'h0000_0000, 32'h8000_0000},
  parameter logic [NSLV*AW-1:0] REGION_MASK = {32'h0000_0000, 32'hF800_0000},
  parameter int DEFAULT_SLV = NSLV,
  parameter int SW = $clog2(NSLV + 1)
) (
  input  logic [AW-1:0] addr,
  output logic [SW-1:0] sel,
  output logic          err
);
  always_comb begin
    sel = SW'(DEFAULT_SLV);
    for (int i = NSLV - 1; i >= 0; i--)
      if ((addr & REGION_MASK[i*AW +: AW]) == REGION_BASE[i*AW +: AW]) sel = SW'(i);
  end
  assign err = sel == SW'(NSLV);
endmodule

// File: rtl/axi_region_xbar.sv
// axi_region_xbar: 1-to-NSLV AXI4 crossbar routing on address, select latched per transaction, local DECERR
module axi_region_xbar import axi_pkg::*; #(
  parameter int NSLV = 2,
  parameter int DW = 64,
  parameter int AW = 32,
  parameter logic [NSLV*AW-1:0] REGION_BASE = {32'h0000_0000, 32'h8000_0000},
  parameter logic [NSLV*AW-1:0] REGION_MASK = {32'h0000_0000, 32'hF800_0000},
  parameter int DEFAULT_SLV = NSLV
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        s_araddr,
  input  logic [7:0]           s_arlen,
  input  logic [2:0]           s_arsize,
  input  logic [1:0]           s_arburst,
  input  logic                 s_arvalid,
  output logic                 s_arready,
  output logic [DW-1:0]        s_rdata,
  output logic [1:0]           s_rresp,
  output logic                 s_rlast,
  output logic                 s_rvalid,
  input  logic                 s_rready,
  input  logic [AW-1:0]        s_awaddr,
  input  logic [7:0]           s_awlen,
  input  logic [1:0]           s_awburst,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [DW-1:0]        s_wdata,
  input  logic [DW/8-1:0]      s_wstrb,
  input  logic                 s_wlast,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  output logic [1:0]           s_bresp,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  output logic [NSLV*AW-1:0]   m_araddr,
  output logic [NSLV*8-1:0]    m_arlen,
  output logic [NSLV*3-1:0]    m_arsize,
  output logic [NSLV*2-1:0]    m_arburst,
  output logic [NSLV-1:0]      m_arvalid,
  input  logic [NSLV-1:0]      m_arready,
  input  logic [NSLV*DW-1:0]   m_rdata,
  input  logic [NSLV*2-1:0]    m_rresp,
  input  logic [NSLV-1:0]      m_rlast,
  input  logic [NSLV-1:0]      m_rvalid,
  output logic [NSLV-1:0]      m_rready,
  output logic [NSLV*AW-1:0]   m_awaddr,
  output logic [NSLV*8-1:0]    m_awlen,
  output logic [NSLV*2-1:0]    m_awburst,
  output logic [NSLV-1:0]      m_awvalid,
  input  logic [NSLV-1:0]      m_awready,
  output logic [NSLV*DW-1:0]   m_wdata,
  output logic [NSLV*DW/8-1:0] m_wstrb,
  output logic [NSLV-1:0]      m_wlast,
  output logic [NSLV-1:0]      m_wvalid,
  input  logic [NSLV-1:0]      m_wready,
  input  logic [NSLV*2-1:0]    m_bresp,
  input  logic [NSLV-1:0]      m_bvalid,
  output logic [NSLV-1:0]      m_bready
);
  localparam int SW = $clog2(NSLV + 1);
  logic [SW-1:0] ar_sel, aw_sel, rsel_q, rsel_d, wsel_q, wsel_d;
  logic ar_err, aw_err, ar_req, aw_req;
  logic [7:0] rcnt_q, rcnt_d;
  rd_state_t rd_q, rd_d;
  wr_state_t wr_q, wr_d;
  axi_addr_decode #(.NSLV(NSLV), .AW(AW), .REGION_BASE(REGION_BASE), .REGION_MASK(REGION_MASK),
    .DEFAULT_SLV(DEFAULT_SLV), .SW(SW)) u_ar_dec (.addr(s_araddr), .sel(ar_sel), .err(ar_err));
  axi_addr_decode #(.NSLV(NSLV), .AW(AW), .REGION_BASE(REGION_BASE), .REGION_MASK(REGION_MASK),
    .DEFAULT_SLV(DEFAULT_SLV), .SW(SW)) u_aw_dec (.addr(s_awaddr), .sel(aw_sel), .err(aw_err));
  // payloads fan out to every port; only the selected valid qualifies them
  assign m_araddr  = {NSLV{s_araddr}};
  assign m_arlen   = {NSLV{s_arlen}};
  assign m_arsize  = {NSLV{s_arsize}};
  assign m_arburst = {NSLV{s_arburst}};
  assign m_awaddr  = {NSLV{s_awaddr}};
  assign m_awlen   = {NSLV{s_awlen}};
  assign m_awburst = {NSLV{s_awburst}};
  assign m_wdata   = {NSLV{s_wdata}};
  assign m_wstrb   = {NSLV{s_wstrb}};
  assign m_wlast   = {NSLV{s_wlast}};
  // address forwarding is combinational in IDLE, so reset must mask it explicitly
  assign ar_req = rd_q == RD_IDLE && !rst && s_arvalid;
  assign aw_req = wr_q == WR_IDLE && !rst && s_awvalid;
  always_comb begin
    m_arvalid = '0;
    m_rready = '0;
    s_arready = ar_req && ar_err;
    s_rvalid = rd_q == RD_ERR;
    s_rdata = '0;
    s_rresp = rd_q == RD_ERR ? AXI_RESP_DECERR : AXI_RESP_OKAY;
    s_rlast = rd_q == RD_ERR && rcnt_q == 8'd0;
    for (int i = 0; i < NSLV; i++) begin
      if (ar_req && ar_sel == SW'(i)) begin
        m_arvalid[i] = 1'b1;
        s_arready = m_arready[i];
      end
      if (rd_q == RD_FWD && rsel_q == SW'(i)) begin
        s_rvalid = m_rvalid[i];
        s_rdata = m_rdata[i*DW +: DW];
        s_rresp = m_rresp[i*2 +: 2];
        s_rlast = m_rlast[i];
        m_rready[i] = s_rready;
      end
    end
  end
  always_comb begin
    m_awvalid = '0;
    m_wvalid = '0;
    m_bready = '0;
    s_awready = aw_req && aw_err;
    s_wready = wr_q == WR_ERRD;
    s_bvalid = wr_q == WR_ERRB;
    s_bresp = wr_q == WR_ERRB ? AXI_RESP_DECERR : AXI_RESP_OKAY;
    for (int i = 0; i < NSLV; i++) begin
      if (aw_req && aw_sel == SW'(i)) begin
        m_awvalid[i] = 1'b1;
        s_awready = m_awready[i];
      end
      if (wr_q == WR_DATA && wsel_q == SW'(i)) begin
        m_wvalid[i] = s_wvalid;
        s_wready = m_wready[i];
      end
      if (wr_q == WR_RESP && wsel_q == SW'(i)) begin
        s_bvalid = m_bvalid[i];
        s_bresp = m_bresp[i*2 +: 2];
        m_bready[i] = s_bready;
      end
    end
  end
  always_comb begin
    rd_d = rd_q;
    rsel_d = rsel_q;
    rcnt_d = rcnt_q;
    case (rd_q)
      RD_IDLE: if (s_arvalid && s_arready) begin
        rsel_d = ar_sel;
        rcnt_d = s_arlen;
        rd_d = ar_err ? RD_ERR : RD_FWD;
      end
      RD_FWD: rd_d = s_rvalid && s_rready && s_rlast ? RD_IDLE : RD_FWD;
      RD_ERR: if (s_rready) begin
        rcnt_d = rcnt_q - 8'd1;
        rd_d = s_rlast ? RD_IDLE : RD_ERR;
      end
      default: rd_d = RD_IDLE;
    endcase
  end
  always_comb begin
    wr_d = wr_q;
    wsel_d = wsel_q;
    case (wr_q)
      WR_IDLE: if (s_awvalid && s_awready) begin
        wsel_d = aw_sel;
        wr_d = aw_err ? WR_ERRD : WR_DATA;
      end
      WR_DATA: wr_d = s_wvalid && s_wready && s_wlast ? WR_RESP : WR_DATA;
      WR_RESP: wr_d = s_bvalid && s_bready ? WR_IDLE : WR_RESP;
      WR_ERRD: wr_d = s_wvalid && s_wlast ? WR_ERRB : WR_ERRD;
      WR_ERRB: wr_d = s_bready ? WR_IDLE : WR_ERRB;
      default: wr_d = WR_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= RD_IDLE;
      wr_q <= WR_IDLE;
      rsel_q <= '0;
      wsel_q <= '0;
      rcnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      rsel_q <= rsel_d;
      wsel_q <= wsel_d;
      rcnt_q <= rcnt_d;
    end
  end
endmodule

// File: tb/tb_axi_region_xbar.sv
// tb_axi_region_xbar: directed vector table plus hand-written burst sequences for axi_region_xbar
module tb_axi_region_xbar;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] s_araddr = '0, s_awaddr = '0;
  logic [7:0] s_arlen = '0, s_awlen = '0;
  logic [2:0] s_arsize = 3'd3;
  logic [1:0] s_arburst = 2'b01, s_awburst = 2'b01;
  logic s_arvalid = 0, s_arready, s_rlast, s_rvalid, s_rready = 0;
  logic [63:0] s_rdata, s_wdata = '0;
  logic [1:0] s_rresp, s_bresp;
  logic s_awvalid = 0, s_awready, s_wlast = 0, s_wvalid = 0, s_wready, s_bvalid, s_bready = 0;
  logic [7:0] s_wstrb = '0;
  logic [63:0] m_araddr, m_awaddr;
  logic [15:0] m_arlen, m_awlen, m_wstrb;
  logic [5:0] m_arsize;
  logic [3:0] m_arburst, m_awburst;
  logic [1:0] m_arvalid, m_arready = '0, m_rlast = '0, m_rvalid = '0, m_rready;
  logic [127:0] m_rdata = '0, m_wdata;
  logic [3:0] m_rresp = '0, m_bresp = '0;
  logic [1:0] m_awvalid, m_awready = '0, m_wlast, m_wvalid, m_wready = '0, m_bvalid = '0, m_bready;
  logic [31:0] ov_addr;
  logic [1:0] ov_sel;
  logic ov_err;
  int checks = 0, errors = 0;
  logic mon = 0, ar0_seen = 0;
  always #5 clk = ~clk;
  axi_region_xbar #(.NSLV(2), .DW(64), .AW(32),
    .REGION_BASE({32'h8000_0000, 32'hA000_0000}), .REGION_MASK({32'hF800_0000, 32'hF800_0000}),
    .DEFAULT_SLV(2)) dut (
    .clk(clk), .rst(rst),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst), .s_awvalid(s_awvalid),
    .s_awready(s_awready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awburst(m_awburst), .m_awvalid(m_awvalid),
    .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready));
  axi_addr_decode #(.NSLV(2), .AW(32), .REGION_BASE({32'h0000_0000, 32'h8000_0000}),
    .REGION_MASK({32'h0000_0000, 32'hF800_0000}), .DEFAULT_SLV(2), .SW(2))
    u_ov (.addr(ov_addr), .sel(ov_sel), .err(ov_err));
  always @(posedge clk) if (mon && m_arvalid[0]) ar0_seen <= 1'b1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  typedef struct {logic [31:0] addr; logic [1:0] exp_v; logic exp_rdy;} vec_t;
  vec_t vecs[8];
  initial begin
    vecs[0] = '{32'hA000_0000, 2'b01, 1'b1};
    vecs[1] = '{32'hA7FF_FFFF, 2'b01, 1'b1};
    vecs[2] = '{32'hA800_0000, 2'b00, 1'b1};
    vecs[3] = '{32'h8000_1000, 2'b10, 1'b0};
    vecs[4] = '{32'h87FF_FFFF, 2'b10, 1'b0};
    vecs[5] = '{32'h8800_0000, 2'b00, 1'b1};
    vecs[6] = '{32'h4000_0000, 2'b00, 1'b1};
    vecs[7] = '{32'h9FFF_FFFF, 2'b00, 1'b1};
    s_araddr = 32'hA000_0000; s_awaddr = 32'h8000_0000;
    s_arvalid = 1; s_awvalid = 1; m_arready = 2'b11; m_awready = 2'b11;
    #2;
    chk("rst_arready", s_arready, 0);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_awready", s_awready, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_rvalid", {s_rvalid, s_rresp, s_rdata}, 0);
    chk("rst_w_b", {s_wready, s_bvalid, s_bresp, m_wvalid, m_rready, m_bready}, 0);
    @(negedge clk);
    s_arvalid = 0; s_awvalid = 0; rst = 0;
    ov_addr = 32'h8000_0000; #1 chk("overlap_lowest", {ov_err, ov_sel}, 3'b000);
    ov_addr = 32'h0000_1234; #1 chk("overlap_catchall", {ov_err, ov_sel}, 3'b001);
    m_arready = 2'b01; m_awready = 2'b01;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_araddr = vecs[i].addr; s_awaddr = vecs[i].addr; s_arvalid = 1; s_awvalid = 1;
      #1;
      chk($sformatf("vec%0d_m_arvalid", i), m_arvalid, vecs[i].exp_v);
      chk($sformatf("vec%0d_arready", i), s_arready, vecs[i].exp_rdy);
      chk($sformatf("vec%0d_m_awvalid", i), m_awvalid, vecs[i].exp_v);
      chk($sformatf("vec%0d_awready", i), s_awready, vecs[i].exp_rdy);
      s_arvalid = 0; s_awvalid = 0;
    end
    // read burst to slave1, address changes mid-burst
    @(negedge clk);
    mon = 1;
    s_araddr = 32'h8000_1000; s_arlen = 3; s_arvalid = 1; m_arready = 2'b10;
    #1 chk("rd1_m_arvalid", m_arvalid, 2'b10);
    chk("rd1_arready", s_arready, 1);
    @(negedge clk);
    s_arvalid = 0; m_arready = 0; s_rready = 1;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 2'b11;
      m_rdata = {64'(b + 1) * 64'h11, 64'h0BAD};
      m_rlast = {b == 3, 1'b1};
      if (b == 1 || b == 2) begin
        s_araddr = 32'hA000_0000; s_arvalid = 1; m_arready = 2'b11;
      end else begin
        s_arvalid = 0; m_arready = 0;
      end
      #1;
      chk($sformatf("rd1_b%0d_rvalid", b), s_rvalid, 1);
      chk($sformatf("rd1_b%0d_rdata", b), s_rdata, 64'(b + 1) * 64'h11);
      chk($sformatf("rd1_b%0d_rlast", b), s_rlast, b == 3);
      chk($sformatf("rd1_b%0d_m_rready", b), m_rready, 2'b10);
      chk($sformatf("rd1_b%0d_arready", b), s_arready, 0);
      @(negedge clk);
    end
    s_arvalid = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0;
    #1 chk("rd1_done_rvalid", s_rvalid, 0);
    mon = 0;
    chk("rd1_no_m_arvalid0", ar0_seen, 0);
    // write to slave0, W held back until AW completes
    @(negedge clk);
    s_awaddr = 32'hA000_0000; s_awlen = 0; s_awvalid = 1; m_awready = 0;
    s_wdata = 64'hDEAD; s_wstrb = 8'hFF; s_wlast = 1; s_wvalid = 1; m_wready = 2'b11;
    #1 chk("wr_early_m_wvalid", m_wvalid, 0);
    chk("wr_early_wready", s_wready, 0);
    chk("wr_m_awvalid", m_awvalid, 2'b01);
    @(negedge clk);
    m_awready = 2'b01;
    #1 chk("wr_awready", s_awready, 1);
    @(negedge clk);
    s_awvalid = 0; m_awready = 0; m_wready = 2'b01;
    #1 chk("wr_m_wvalid", m_wvalid, 2'b01);
    chk("wr_m_wdata", m_wdata[63:0], 64'hDEAD);
    chk("wr_m_wstrb", m_wstrb[7:0], 8'hFF);
    chk("wr_wready", s_wready, 1);
    @(negedge clk);
    s_wvalid = 0; m_wready = 0; m_bvalid = 2'b11; m_bresp = 4'b1100; s_bready = 1;
    #1 chk("wr_bvalid", s_bvalid, 1);
    chk("wr_bresp", s_bresp, 2'b00);
    chk("wr_m_bready", m_bready, 2'b01);
    @(negedge clk);
    m_bvalid = 0; m_bresp = 0; s_bready = 0;
    s_awvalid = 1; m_awready = 0;
    #1 chk("wr_back_idle", m_awvalid, 2'b01);
    s_awvalid = 0;
    // decode-error read, two beats
    @(negedge clk);
    s_araddr = 32'h4000_0000; s_arlen = 1; s_arvalid = 1; s_rready = 0; m_arready = 2'b11;
    #1 chk("de_arready", s_arready, 1);
    chk("de_m_arvalid", m_arvalid, 0);
    @(negedge clk);
    s_arvalid = 0;
    #1 chk("de_stall", {s_rvalid, s_rresp, s_rlast, s_rdata}, {1'b1, 2'b11, 1'b0, 64'h0});
    @(negedge clk);
    s_rready = 1;
    #1 chk("de_b0", {s_rvalid, s_rresp, s_rlast, s_rdata}, {1'b1, 2'b11, 1'b0, 64'h0});
    @(negedge clk);
    #1 chk("de_b1", {s_rvalid, s_rresp, s_rlast, s_rdata}, {1'b1, 2'b11, 1'b1, 64'h0});
    chk("de_m_rready", m_rready, 0);
    @(negedge clk);
    s_rready = 0; m_arready = 0;
    #1 chk("de_done", s_rvalid, 0);
    // decode-error write: data swallowed, DECERR held until bready
    @(negedge clk);
    s_awaddr = 32'h4000_0000; s_awvalid = 1;
    #1 chk("dw_awready", s_awready, 1);
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 1; s_wlast = 0; m_wready = 2'b11;
    #1 chk("dw_wready", {s_wready, m_wvalid}, 3'b100);
    @(negedge clk);
    s_wlast = 1;
    @(negedge clk);
    s_wvalid = 0; s_wlast = 0;
    #1 chk("dw_bhold", {s_bvalid, s_bresp}, 3'b111);
    @(negedge clk);
    s_bready = 1;
    #1 chk("dw_b", {s_bvalid, s_bresp}, 3'b111);
    @(negedge clk);
    s_bready = 0; m_wready = 0;
    #1 chk("dw_done", s_bvalid, 0);
    // concurrent read to slave0 and write to slave1
    @(negedge clk);
    s_araddr = 32'hA000_0010; s_arlen = 0; s_arvalid = 1; m_arready = 2'b01;
    s_awaddr = 32'h8000_0000; s_awvalid = 1; m_awready = 2'b10;
    #1 chk("cc_m_arvalid", m_arvalid, 2'b01);
    chk("cc_m_awvalid", m_awvalid, 2'b10);
    chk("cc_ready", {s_arready, s_awready}, 2'b11);
    @(negedge clk);
    s_arvalid = 0; s_awvalid = 0; m_arready = 0; m_awready = 0;
    m_rvalid = 2'b01; m_rdata = {64'h0BAD, 64'hCAFE}; m_rlast = 2'b01; s_rready = 1;
    s_wvalid = 1; s_wlast = 1; s_wdata = 64'hBEEF; m_wready = 2'b10;
    #1 chk("cc_rdata", {s_rvalid, s_rlast, s_rdata}, {2'b11, 64'hCAFE});
    chk("cc_m_wvalid", m_wvalid, 2'b10);
    chk("cc_m_rready", m_rready, 2'b01);
    chk("cc_m_wdata1", m_wdata[127:64], 64'hBEEF);
    @(negedge clk);
    m_rvalid = 0; m_rlast = 0; s_rready = 0; s_wvalid = 0; s_wlast = 0; m_wready = 0;
    m_bvalid = 2'b11; m_bresp = 4'b1000; s_bready = 1;
    #1 chk("cc_b", {s_bvalid, s_bresp}, 3'b110);
    chk("cc_m_bready", m_bready, 2'b10);
    chk("cc_r_idle", s_rvalid, 0);
    @(negedge clk);
    m_bvalid = 0; m_bresp = 0; s_bready = 0;
    // reset during a read burst and a write data phase
    @(negedge clk);
    s_araddr = 32'h8000_1000; s_arlen = 3; s_arvalid = 1; m_arready = 2'b10;
    s_awaddr = 32'hA000_0000; s_awvalid = 1; m_awready = 2'b01;
    @(negedge clk);
    s_arvalid = 0; s_awvalid = 0; m_arready = 0; m_awready = 0;
    m_rvalid = 2'b10; m_rlast = 0; s_rready = 1;
    @(negedge clk);
    s_wvalid = 1; m_wready = 2'b01;
    s_arvalid = 1; s_awvalid = 1; m_arready = 2'b11; m_awready = 2'b11;
    #1 chk("rs_pre", {s_rvalid, m_wvalid, s_arready}, 4'b1010);
    rst = 1;
    #1 chk("rs_r", {s_rvalid, m_rready, s_arready, m_arvalid}, 0);
    chk("rs_w", {s_wready, m_wvalid, s_awready, m_awvalid, s_bvalid, m_bready}, 0);
    @(negedge clk);
    rst = 0; s_arvalid = 0; s_awvalid = 0; s_wvalid = 0; m_wready = 0; m_rvalid = 0; s_rready = 0;
    m_arready = 0; m_awready = 0;
    @(negedge clk);
    s_araddr = 32'hA000_0000; s_arlen = 0; s_arvalid = 1; m_arready = 2'b01;
    s_awaddr = 32'h8000_0000; s_awvalid = 1;
    #1 chk("rs_ar_idle", {m_arvalid, s_arready}, 3'b011);
    chk("rs_aw_idle", m_awvalid, 2'b10);
    s_awvalid = 0;
    @(negedge clk);
    s_arvalid = 0; m_arready = 0;
    m_rvalid = 2'b01; m_rdata = {64'h0, 64'h77}; m_rlast = 2'b01; s_rready = 1;
    #1 chk("rs_next_rd", {s_rvalid, s_rlast, s_rdata}, {2'b11, 64'h77});
    @(negedge clk);
    m_rvalid = 0; m_rlast = 0; s_rready = 0;
    #1 chk("rs_next_done", s_rvalid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
